// File: rtl/decode_queue.sv
// Decode-stage instruction queue: circular buffer of {instr, pc} entries with
// stall/flush control and combinational field decode of the head entry.
module decode_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_func3,
    output logic [6:0]                 out_func7,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    entry_t        w_head;

    assign in_ready  = (r_count < CW'(DEPTH)) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && !stall && !flush;
    assign count     = r_count;

    // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{instr: in_instr, pc: in_pc};
    end

    always_comb begin
        w_head = '{instr: NOP_INSTR, pc: '0};
        if (out_valid) w_head = r_mem[r_rptr];
    end

    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;
    assign out_opcode  = w_head.instr[6:0];
    assign out_func3   = w_head.instr[14:12];
    assign out_func7   = w_head.instr[31:25];
    assign out_rs1     = w_head.instr[19:15];
    assign out_rs2     = w_head.instr[24:20];
    assign out_rd      = w_head.instr[11:7];
    assign out_illegal = out_valid && (w_head.instr[1:0] != 2'b11);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, XLEN=32) with hand-computed expectations.
module tb_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            stall;
    logic            flush;
    logic            out_valid;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic [1:0]      count;

    int passed = 0;
    int total  = 0;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle; inputs are changed only after this.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        offer(1'b0, 32'h0, '0);
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_instr", out_instr, 32'h13);
        chk("rst_pc", out_pc, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_opcode", out_opcode, 7'h13);

        // Single push, visible after one edge
        offer(1'b1, 32'h00500093, 32'h100);
        step();
        offer(1'b0, 32'h0, '0);
        chk("p1_valid", out_valid, 1);
        chk("p1_rd", out_rd, 1);
        chk("p1_opcode", out_opcode, 7'h13);
        chk("p1_count", count, 1);
        chk("p1_pc", out_pc, 32'h100);
        step();
        chk("p1_drain", count, 0);

        // Field decode of an R-type (sub x10,x10,x11)
        offer(1'b1, 32'h40B50533, 32'h40);
        step();
        offer(1'b0, 32'h0, '0);
        chk("r_func7", out_func7, 7'h20);
        chk("r_rs2", out_rs2, 11);
        chk("r_rs1", out_rs1, 10);
        chk("r_func3", out_func3, 0);
        chk("r_rd", out_rd, 10);
        chk("r_opcode", out_opcode, 7'h33);
        step();

        // Stall fills the queue; third offer held by fetch
        stall = 1'b1;
        offer(1'b1, 32'h00000093, 32'h0); step();
        offer(1'b1, 32'h00100093, 32'h4); step();
        offer(1'b1, 32'h00200093, 32'h8);
        chk("st_ready", in_ready, 0);
        chk("st_count", count, 2);
        step();
        chk("st_hold_count", count, 2);
        chk("st_head_pc0", out_pc, 32'h0);
        stall = 1'b0;
        step();
        chk("st_head_pc4", out_pc, 32'h4);
        chk("st_cnt_a", count, 1);
        step();
        offer(1'b0, 32'h0, '0);
        chk("st_head_pc8", out_pc, 32'h8);
        chk("st_cnt_b", count, 1);
        step();
        chk("st_empty", count, 0);

        // Flush a full queue while fetch offers
        stall = 1'b1;
        offer(1'b1, 32'h00300093, 32'h10); step();
        offer(1'b1, 32'h00400093, 32'h14); step();
        chk("fl_full", count, 2);
        flush = 1'b1;
        offer(1'b1, 32'hDEADBEEF, 32'h99);
        chk("fl_ready", in_ready, 0);
        step();
        flush = 1'b0; stall = 1'b0;
        offer(1'b0, 32'h0, '0);
        chk("fl_count", count, 0);
        chk("fl_instr", out_instr, 32'h13);
        chk("fl_pc", out_pc, 0);
        chk("fl_valid", out_valid, 0);

        // Flush discards a push even when space is available
        offer(1'b1, 32'h00500093, 32'h20); step();
        flush = 1'b1;
        offer(1'b1, 32'h00600093, 32'h24);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, '0);
        chk("fl2_count", count, 0);
        step();
        chk("fl2_stays", out_valid, 0);

        // Streaming push+pop across pointer wrap
        offer(1'b1, 32'h00000013, 32'h200);
        step();
        chk("str_first", out_pc, 32'h200);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            offer(1'b1, 32'h00000013, 32'h204 + 32'(4 * i));
            step();
            chk("str_count", count, 1);
            chk("str_pc", out_pc, 32'h204 + 32'(4 * i));
        end
        offer(1'b0, 32'h0, '0);
        step();
        chk("str_drain", count, 0);

        // Illegal encodings
        offer(1'b1, 32'h00000000, 32'h300);
        step();
        offer(1'b0, 32'h0, '0);
        chk("ill_zero", out_illegal, 1);
        step();
        chk("ill_empty", out_illegal, 0);
        offer(1'b1, 32'h00000001, 32'h304);
        step();
        offer(1'b0, 32'h0, '0);
        chk("ill_01", out_illegal, 1);
        step();

        // Reset overrides stall with a full queue
        stall = 1'b1;
        offer(1'b1, 32'h00700093, 32'h400); step();
        offer(1'b1, 32'h00800093, 32'h404); step();
        offer(1'b0, 32'h0, '0);
        chk("rs_full", count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_valid", out_valid, 0);
        chk("rs_count", count, 0);
        chk("rs_ready", in_ready, 1);
        chk("rs_pc", out_pc, 0);
        stall = 1'b0;
        step();
        chk("rs_no_ghost", out_instr, 32'h13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning address/PC width; legal values 32 or 64.
REQ-002 SHALL provide parameter DEPTH, default 2, meaning number of instruction entries; power of two, >= 2.
REQ-003 SHALL provide parameter NOP_INSTR, default 32'h00000013, meaning the instruction presented when no entry is valid.
REQ-004 SHALL use one clock; reset is synchronous and active-high; the clock port is clk and the reset port is rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  fetch offers an instruction.
REQ-008 in_ready  output  1  queue can accept an instruction this cycle.
REQ-009 in_instr  input  32  fetched instruction word.
REQ-010 in_pc  input  XLEN  PC of in_instr.
REQ-011 stall  input  1  hazard unit holds the head entry.
REQ-012 flush  input  1  hazard unit discards all entries.
REQ-013 out_valid  output  1  head entry is valid.
REQ-014 out_instr  output  32  head instruction, or NOP_INSTR when not out_valid.
REQ-015 out_pc  output  XLEN  head PC, or 0 when not out_valid.
REQ-016 out_opcode / out_func3 / out_func7  output  7/3/7  fields out_instr[6:0], [14:12], [31:25].
REQ-017 out_rs1 / out_rs2 / out_rd  output  5/5/5  fields out_instr[19:15], [24:20], [11:7].
REQ-018 out_illegal  output  1  out_valid and out_instr[1:0] != 2'b11.
REQ-019 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 SHALL store entries {instr, pc} in a circular buffer with write pointer, read pointer and count registers.
REQ-021 in_ready SHALL equal (count < DEPTH) and not flush; no write-through when full.
REQ-022 push SHALL occur when in_valid and in_ready; the entry is written at the write pointer, which advances modulo DEPTH.
REQ-023 pop SHALL occur when out_valid and not stall and not flush; read pointer advances modulo DEPTH.
REQ-024 out_valid SHALL equal (count != 0); all out_* fields SHALL be driven combinationally from the head entry.
REQ-025 Latency in to out SHALL be exactly one cycle: an entry pushed at edge N is visible at the head after edge N only if the queue was empty or emptied by that pop.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; order SHALL be strictly FIFO.
REQ-027 stall SHALL freeze the read pointer and head outputs; pushes continue until full.
REQ-028 flush SHALL, at the next edge, set count, read and write pointers to 0; any push offered in the flush cycle is discarded.
REQ-029 flush SHALL take priority over stall and over push/pop.
REQ-030 When count == 0 the outputs SHALL be out_instr = NOP_INSTR, out_pc = 0, out_illegal = 0, fields decoded from NOP_INSTR.
REQ-031 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless with no bubble.
REQ-032 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-033 On rst high at a clk edge, count, pointers SHALL be 0; out_valid = 0, in_ready = 1 the following cycle, out_instr = NOP_INSTR, out_pc = 0.
REQ-034 rst SHALL override flush, stall, push and pop; entries stored before reset SHALL never appear at the output afterwards.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 Reset, then push 0x00500093 @ pc 0x100 -> next cycle out_valid = 1, out_rd = 1, out_opcode = 0x13, count = 1.
REQ-037 DEPTH = 2, stall = 1, push 3 instructions back-to-back -> count = 2, in_ready = 0, third held by fetch; release stall -> FIFO order pc 0x0, 0x4, 0x8.
REQ-038 Queue with 2 entries, flush = 1 with in_valid = 1 -> next cycle count = 0, out_instr = 0x00000013, out_pc = 0, pushed word not present.
REQ-039 Continuous push and pop for 3*DEPTH cycles -> count constant at 1, PCs increment by 4 across pointer wrap, no bubble.
REQ-040 Push 0x00000000 -> out_illegal = 1; with queue empty -> out_illegal = 0.
REQ-041 rst asserted while count = 2 and stall = 1 -> next cycle out_valid = 0, count = 0, in_ready = 1.
